// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, FSM state type and frame-length helper
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  // Clock cycles occupied by one complete frame on the line.
  function automatic int frame_ticks(input int data_bits, input int parity_mode,
                                     input int stop_bits, input int ticks_per_bit);
    return (1 + data_bits + ((parity_mode != PARITY_NONE) ? 1 : 0) + stop_bits) * ticks_per_bit;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - circular FIFO with occupancy count and registered read port
module uart_sync_fifo #(
  parameter int Width = 8,
  parameter int Depth = 256
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   push,
  input  logic [Width-1:0]       push_data,
  input  logic                   pop,
  output logic [Width-1:0]       pop_data,
  output logic [$clog2(Depth):0] count,
  output logic                   full
);

  localparam int AW = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic             do_push;
  logic             do_pop;

  // The count register lets every entry be used while still telling full from empty.
  assign full    = (count == (AW+1)'(Depth));
  assign do_push = push && !full;
  assign do_pop  = pop && (count != '0);

  // Storage array write; contents are don't-care until pushed, so no reset.
  always_ff @(posedge CLK) begin
    if (do_push) mem[head] <= push_data;
  end

  // Pointers wrap naturally at the power-of-two depth; popped word is registered.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      pop_data <= '0;
    end else begin
      if (do_push) head <= head + AW'(1);
      if (do_pop) begin
        tail     <= tail + AW'(1);
        pop_data <= mem[tail];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - FIFO-buffered UART transmitter; optional flow control via UART_TX_CTS_EN
module uart_tx
  import uart_pkg::*;
#(
  parameter int ClockFrequency = 50_000_000,
  parameter int BaudRate       = 115200,
  parameter int DataBits       = 8,
  parameter int ParityMode     = 0,
  parameter int StopBits       = 1,
  parameter int FifoDepth      = 256
) (
  input  logic                       CLK,
  input  logic                       RST,
`ifdef UART_TX_CTS_EN
  input  logic                       i_cts_n,
`endif
  input  logic                       i_valid,
  input  logic [DataBits-1:0]        i_data,
  output logic                       o_ready,
  output logic                       o_data,
  output logic                       o_busy,
  output logic [$clog2(FifoDepth):0] o_fifo_level
);

  localparam int TicksPerBit = ClockFrequency / BaudRate;
  localparam int TW = $clog2(TicksPerBit);
  localparam int BW = $clog2(DataBits + 1);
  localparam logic [TW-1:0] TickLast  = TW'(TicksPerBit - 1);
  localparam logic [BW-1:0] DataLast  = BW'(DataBits - 1);
  localparam logic [BW-1:0] StopLast  = BW'(StopBits - 1);
  localparam logic          ParityOdd = (ParityMode == PARITY_ODD);

  uart_state_t               state;
  logic [TW-1:0]             tick_cnt;
  logic [BW-1:0]             bit_cnt;
  logic [DataBits-1:0]       shift;
  logic                      parity_bit;
  logic                      load_pending;
  logic                      fifo_pop;
  logic                      fifo_full;
  logic [DataBits-1:0]       fifo_pop_data;
  logic [$clog2(FifoDepth):0] fifo_count;
  logic                      start_ok;
  logic                      tick_last;
  logic                      stop_done;

  uart_sync_fifo #(
    .Width (DataBits),
    .Depth (FifoDepth)
  ) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (i_valid),
    .push_data (i_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_pop_data),
    .count     (fifo_count),
    .full      (fifo_full)
  );

  assign o_ready      = !fifo_full;
  assign o_fifo_level = fifo_count;

`ifdef UART_TX_CTS_EN
  logic cts_meta;
  logic cts_sync;

  // Two-flop synchroniser; resets to "not clear" so nothing starts before CTS is seen.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cts_meta <= 1'b1;
      cts_sync <= 1'b1;
    end else begin
      cts_meta <= i_cts_n;
      cts_sync <= cts_meta;
    end
  end

  assign start_ok = !cts_sync;
`else
  assign start_ok = 1'b1;
`endif

  assign tick_last = (tick_cnt == TickLast);
  assign stop_done = (state == ST_STOP) && tick_last && (bit_cnt == StopLast);

  // Pop from IDLE (word reaches the read register one cycle later) or on the last stop tick.
  always_comb begin
    fifo_pop = 1'b0;
    if (start_ok && (fifo_count != '0)) begin
      if ((state == ST_IDLE) && !load_pending) fifo_pop = 1'b1;
      else if (stop_done)                      fifo_pop = 1'b1;
    end
  end

  // Frame sequencer; the word is taken from the FIFO read register at the end of START.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state        <= ST_IDLE;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      shift        <= '0;
      parity_bit   <= 1'b0;
      load_pending <= 1'b0;
      o_data       <= 1'b1;
      o_busy       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          o_data   <= 1'b1;
          tick_cnt <= '0;
          bit_cnt  <= '0;
          if (load_pending) begin
            load_pending <= 1'b0;
            state        <= ST_START;
            o_data       <= 1'b0;
            o_busy       <= 1'b1;
          end else if (fifo_pop) begin
            load_pending <= 1'b1;
          end
        end
        ST_START: begin
          if (tick_last) begin
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shift      <= fifo_pop_data >> 1;
            parity_bit <= (^fifo_pop_data) ^ ParityOdd;
            o_data     <= fifo_pop_data[0];
            state      <= ST_DATA;
          end else begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
        ST_DATA: begin
          if (tick_last) begin
            tick_cnt <= '0;
            if (bit_cnt == DataLast) begin
              bit_cnt <= '0;
              if (ParityMode != PARITY_NONE) begin
                state  <= ST_PARITY;
                o_data <= parity_bit;
              end else begin
                state  <= ST_STOP;
                o_data <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
              o_data  <= shift[0];
              shift   <= shift >> 1;
            end
          end else begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
        ST_PARITY: begin
          if (tick_last) begin
            tick_cnt <= '0;
            state    <= ST_STOP;
            o_data   <= 1'b1;
          end else begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
        ST_STOP: begin
          if (tick_last) begin
            tick_cnt <= '0;
            if (bit_cnt == StopLast) begin
              bit_cnt <= '0;
              if (fifo_pop) begin
                state  <= ST_START;
                o_data <= 1'b0;
              end else begin
                state  <= ST_IDLE;
                o_busy <= 1'b0;
              end
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end else begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx across several configurations
module tb_uart_tx;

  localparam int T = 434;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       cts_n = 1'b0;
  logic       vin  [5];
  logic [8:0] din  [5];
  logic       od   [5];
  logic       busy [5];
  logic       rdy  [5];
  logic [8:0] lvl0, lvl1, lvl2, lvl4;
  logic [2:0] lvl3;
  logic [8:0] w3 [6];

  int tests = 0;
  int fails = 0;
  int sel   = 0;

  logic       cur_od;
  logic       cur_busy;
  logic [8:0] cur_lvl;

  always #5 CLK = ~CLK;

  always_comb begin
    cur_od   = od[sel];
    cur_busy = busy[sel];
    case (sel)
      0:       cur_lvl = lvl0;
      1:       cur_lvl = lvl1;
      2:       cur_lvl = lvl2;
      3:       cur_lvl = {6'd0, lvl3};
      default: cur_lvl = lvl4;
    endcase
  end

  uart_tx u0 (.CLK(CLK), .RST(RST),
`ifdef UART_TX_CTS_EN
    .i_cts_n(cts_n),
`endif
    .i_valid(vin[0]), .i_data(din[0][7:0]), .o_ready(rdy[0]), .o_data(od[0]),
    .o_busy(busy[0]), .o_fifo_level(lvl0));

  uart_tx #(.DataBits(7), .ParityMode(2)) u1 (.CLK(CLK), .RST(RST),
`ifdef UART_TX_CTS_EN
    .i_cts_n(cts_n),
`endif
    .i_valid(vin[1]), .i_data(din[1][6:0]), .o_ready(rdy[1]), .o_data(od[1]),
    .o_busy(busy[1]), .o_fifo_level(lvl1));

  uart_tx #(.DataBits(7), .ParityMode(1)) u2 (.CLK(CLK), .RST(RST),
`ifdef UART_TX_CTS_EN
    .i_cts_n(cts_n),
`endif
    .i_valid(vin[2]), .i_data(din[2][6:0]), .o_ready(rdy[2]), .o_data(od[2]),
    .o_busy(busy[2]), .o_fifo_level(lvl2));

  uart_tx #(.FifoDepth(4)) u3 (.CLK(CLK), .RST(RST),
`ifdef UART_TX_CTS_EN
    .i_cts_n(cts_n),
`endif
    .i_valid(vin[3]), .i_data(din[3][7:0]), .o_ready(rdy[3]), .o_data(od[3]),
    .o_busy(busy[3]), .o_fifo_level(lvl3));

  uart_tx #(.StopBits(2)) u4 (.CLK(CLK), .RST(RST),
`ifdef UART_TX_CTS_EN
    .i_cts_n(cts_n),
`endif
    .i_valid(vin[4]), .i_data(din[4][7:0]), .o_ready(rdy[4]), .o_data(od[4]),
    .o_busy(busy[4]), .o_fifo_level(lvl4));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for a start bit on the selected line, then checks first and last cycle of every slot.
  task automatic check_frame(input string tag, input logic [8:0] w, input int nb,
                             input int par, input int nstop);
    logic ex [14];
    int   ns;
    int   n;
    ex[0] = 1'b0;
    for (int i = 0; i < nb; i++) ex[1+i] = w[i];
    ns = 1 + nb;
    if (par >= 0) begin
      ex[ns] = par[0];
      ns++;
    end
    for (int i = 0; i < nstop; i++) begin
      ex[ns] = 1'b1;
      ns++;
    end
    n = 0;
    while (cur_od !== 1'b0 && n < 20000) begin
      @(negedge CLK);
      n++;
    end
    chk({tag, " start seen"}, {31'd0, cur_od}, 32'd0);
    for (int k = 0; k < ns; k++) begin
      chk($sformatf("%s slot%0d first", tag, k), {30'd0, cur_busy, cur_od}, {30'd0, 1'b1, ex[k]});
      repeat (T - 1) @(negedge CLK);
      chk($sformatf("%s slot%0d last", tag, k), {30'd0, cur_busy, cur_od}, {30'd0, 1'b1, ex[k]});
      @(negedge CLK);
    end
  endtask

  task automatic push_one(input int s, input logic [8:0] w);
    @(negedge CLK);
    din[s] = w;
    vin[s] = 1'b1;
    @(negedge CLK);
    vin[s] = 1'b0;
  endtask

  initial begin
    int k, g, acc6, seen;
    logic checked;
    for (int i = 0; i < 5; i++) begin
      vin[i] = 1'b0;
      din[i] = 9'd0;
    end
    w3[0] = 9'h011; w3[1] = 9'h022; w3[2] = 9'h033;
    w3[3] = 9'h044; w3[4] = 9'h055; w3[5] = 9'h066;

    RST = 1'b0;
    repeat (3) @(negedge CLK);
    chk("reset od", {31'd0, od[0]}, 32'd1);
    chk("reset busy", {31'd0, busy[0]}, 32'd0);
    chk("reset ready", {31'd0, rdy[0]}, 32'd1);
    chk("reset level", {23'd0, lvl0}, 32'd0);
    chk("reset depth4 ready", {31'd0, rdy[3]}, 32'd1);
    RST = 1'b1;
    @(negedge CLK);

    // Default 8N1: push latency and the 0xA5 frame.
    sel = 0;
    din[0] = 9'h0A5;
    vin[0] = 1'b1;
    @(negedge CLK);
    vin[0] = 1'b0;
    chk("u0 level after push", {23'd0, lvl0}, 32'd1);
    chk("u0 idle after push", {31'd0, od[0]}, 32'd1);
    @(negedge CLK);
    chk("u0 level after pop", {23'd0, lvl0}, 32'd0);
    chk("u0 idle at N+1", {31'd0, od[0]}, 32'd1);
    @(negedge CLK);
    chk("u0 start at N+2", {31'd0, od[0]}, 32'd0);
    check_frame("u0 A5", 9'h0A5, 8, -1, 1);
    chk("u0 busy after frame", {31'd0, busy[0]}, 32'd0);
    chk("u0 line after frame", {31'd0, od[0]}, 32'd1);
    chk("u0 level after frame", {23'd0, lvl0}, 32'd0);

    // 7 data bits, even then odd parity on 0x41 (two ones).
    sel = 1;
    push_one(1, 9'h041);
    check_frame("u1 even", 9'h041, 7, 0, 1);
    chk("u1 busy after frame", {31'd0, busy[1]}, 32'd0);
    sel = 2;
    push_one(2, 9'h041);
    check_frame("u2 odd", 9'h041, 7, 1, 1);
    chk("u2 busy after frame", {31'd0, busy[2]}, 32'd0);

    // Depth-4 FIFO: producer holds valid for 6 words while frames run back to back.
    sel = 3;
    fork
      begin
        k = 0;
        g = 0;
        acc6 = -1;
        checked = 1'b0;
        while (k < 6 && g < 20000) begin
          @(negedge CLK);
          if (k == 5 && !checked) begin
            chk("u3 ready low when full", {31'd0, rdy[3]}, 32'd0);
            chk("u3 level when full", {29'd0, lvl3}, 32'd4);
            checked = 1'b1;
          end
          din[3] = w3[k];
          vin[3] = 1'b1;
          if (rdy[3]) begin
            if (k == 5) acc6 = g;
            k++;
          end
          g++;
        end
        @(negedge CLK);
        vin[3] = 1'b0;
        chk("u3 all six accepted", k, 6);
        chk("u3 sixth accept cycle", acc6, 4343);
      end
      begin
        for (int f = 0; f < 6; f++) begin
          check_frame($sformatf("u3 f%0d", f), w3[f], 8, -1, 1);
          if (f < 5) chk($sformatf("u3 no gap after f%0d", f), {31'd0, cur_od}, 32'd0);
        end
        chk("u3 busy after burst", {31'd0, busy[3]}, 32'd0);
        chk("u3 level after burst", {23'd0, cur_lvl}, 32'd0);
      end
    join

    // Two stop bits, 0xFF then 0x00.
    sel = 4;
    @(negedge CLK);
    din[4] = 9'h0FF;
    vin[4] = 1'b1;
    @(negedge CLK);
    din[4] = 9'h000;
    @(negedge CLK);
    vin[4] = 1'b0;
    check_frame("u4 FF", 9'h0FF, 8, -1, 2);
    chk("u4 start right after 2 stops", {31'd0, od[4]}, 32'd0);
    check_frame("u4 00", 9'h000, 8, -1, 2);
    chk("u4 busy after frames", {31'd0, busy[4]}, 32'd0);

    // Asynchronous reset mid-frame with words still queued.
    sel = 0;
    @(negedge CLK);
    din[0] = 9'h001;
    vin[0] = 1'b1;
    @(negedge CLK);
    din[0] = 9'h002;
    @(negedge CLK);
    din[0] = 9'h003;
    @(negedge CLK);
    vin[0] = 1'b0;
    repeat (1000) @(negedge CLK);
    chk("u0 busy before reset", {31'd0, busy[0]}, 32'd1);
    chk("u0 level before reset", {23'd0, lvl0}, 32'd2);
    #2;
    RST = 1'b0;
    #1;
    chk("async reset od", {31'd0, od[0]}, 32'd1);
    chk("async reset busy", {31'd0, busy[0]}, 32'd0);
    chk("async reset level", {23'd0, lvl0}, 32'd0);
    chk("async reset ready", {31'd0, rdy[0]}, 32'd1);
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    seen = 0;
    repeat (6000) begin
      @(negedge CLK);
      if (od[0] !== 1'b1 || busy[0] !== 1'b0) seen = 1;
    end
    chk("no output after reset", seen, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
